inject_arbiter: RTL and testbench
=================================

Name: inject_arbiter

Overview:
- Shares the single NoC injection link (tx/credit/data) among NUM_SRC injector sources, such as application parsers and kernel/monitor packet sources.
- Grants are round-robin. A grant is held for a whole burst: it stays locked while the granted source keeps tx asserted.
- Aggregates per-source end-of-application flags into one eoa_o.
- Sits between the injectors and the injection port of the NoC router.

Parameters:
- FLIT_SIZE, 32, flit/data width.
- NUM_SRC, 4, number of requesting sources (2..16).
- STALL_LIMIT, 1024, consecutive no-credit cycles while locked before stall_o asserts.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- src_tx_i  in  NUM_SRC  per-source request/valid; held high for the entire burst.
- src_data_i  in  NUM_SRC x FLIT_SIZE  per-source flit.
- src_credit_o  out  NUM_SRC  per-source credit; only the granted source sees credit.
- src_eoa_i  in  NUM_SRC  per-source end-of-application flag (sticky at the source).
- tx_o  out  1  link valid.
- data_o  out  FLIT_SIZE  link flit.
- credit_i  in  1  link credit from the router.
- eoa_o  out  1  all sources done and link idle.
- grant_o  out  $clog2(NUM_SRC)  index of the granted source; 0 when idle.
- busy_o  out  1  high while in LOCKED.
- stall_o  out  1  credit starvation detected in the current grant.
- flit_cnt_o  out  32  flits transferred in the current or last grant.

Behaviour:
- Flit transfer definition: a flit transfers on a posedge where tx_o=1 and credit_i=1.
- Reset (async, rst_i=1):
  - state=IDLE, rr_ptr=0.
  - tx_o=0, data_o=0, src_credit_o=0, grant_o=0, busy_o=0, stall_o=0, flit_cnt_o=0, eoa_o=0.
  - Reset mid-burst abandons the burst immediately, with no flush. Outputs stay at reset values until the first posedge after deassertion.
- FSM state IDLE:
  - Outputs: tx_o=0, data_o=0, src_credit_o=0.
  - If any src_tx_i is high at the posedge, select the first requester scanning from rr_ptr upward (mod NUM_SRC).
  - Load grant, clear flit_cnt and stall counter, go to LOCKED.
  - Arbitration latency is 1 cycle from request to the first credit.
- FSM state LOCKED (combinational mux, zero added latency):
  - tx_o = src_tx_i[g]; data_o = src_data_i[g].
  - src_credit_o[g] = credit_i; all other src_credit_o bits are 0.
  - flit_cnt increments on each transfer and saturates at 2^32-1.
  - If src_tx_i[g]=0 at a posedge, go to IDLE with rr_ptr=(g+1) mod NUM_SRC. flit_cnt_o holds its value until the next grant.
  - Exactly one IDLE cycle separates consecutive grants.
- Requests from non-granted sources are ignored while LOCKED. They must hold src_tx_i and receive no credit.
- Simultaneous requests in IDLE: lowest index at or after rr_ptr wins. This guarantees no starvation; each requester waits at most NUM_SRC-1 bursts.
- Stall detection:
  - While LOCKED with tx_o=1 and credit_i=0, the stall counter increments; any transfer clears it.
  - When the counter reaches STALL_LIMIT, stall_o=1.
  - stall_o stays sticky until LOCKED exits. It is status only; it does not break the grant.
- eoa_o: registered. It is 1 when all src_eoa_i=1, state=IDLE and no src_tx_i is high. Once set it stays 1 until reset.
- grant_o and busy_o are registered from the state; grant_o is 0 in IDLE.

Decomposition:
- Shared package inject_pkg:
  - FSM enum (IDLE, LOCKED).
  - Default FLIT_SIZE.
  - Flit typedef logic [FLIT_SIZE-1:0].
- One natural sub-module: rr_picker. It is a combinational round-robin priority encoder with inputs (req vector, rr_ptr) and outputs (index, found).

Test Plan:
- Single source: src 0 sends 5 flits with credit always 1, then drops tx. Expect grant_o=0, 5 flits on data_o in order, flit_cnt_o=5, return to IDLE, and the next rr_ptr=1.
- Contention: sources 0, 2 and 3 request together at rr_ptr=0, each with 3 flits. Expect grant order 0, 2, 3, one IDLE cycle between grants, and src_credit_o never given to a non-granted source.
- Backpressure: credit_i toggles 1,0,0,1 during a 4-flit burst. Expect exactly 4 transfers, with data_o held stable while credit_i=0.
- Stall: STALL_LIMIT=8 and credit_i held 0 while locked. Expect stall_o=1 on the 8th stall cycle, and stall_o cleared in the cycle after the source drops tx.
- Async reset mid-burst: rst_i asserted between clock edges on the 3rd flit. Expect tx_o=0 and src_credit_o=0 immediately. After release, a re-request from source 1 is granted with rr_ptr=0 priority.
- EOA: all src_eoa_i=1 while source 2 is still locked. Expect eoa_o=0 until the burst ends, then eoa_o=1 after IDLE is reached, and it stays 1.

Source files
------------

// File: rtl/inject_pkg.sv
// rtl/inject_pkg.sv - shared types for the NoC injection arbiter
package inject_pkg;

  localparam int DEFAULT_FLIT_SIZE = 32;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  typedef logic [DEFAULT_FLIT_SIZE-1:0] flit_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin priority encoder
// Returns the first asserted request at or after ptr_i, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  logic [PW-1:0] cand;

  // Scan farthest offset first so the nearest requester overwrites the result.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inject_arbiter.sv
// rtl/inject_arbiter.sv - round-robin burst-locked arbiter for the NoC injection link
// Grants one source per burst, muxes its tx/data/credit and tracks stall and end-of-application.
module inject_arbiter
  import inject_pkg::*;
#(
  parameter int FLIT_SIZE   = DEFAULT_FLIT_SIZE,
  parameter int NUM_SRC     = 4,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_SRC-1:0]                src_tx_i,
  input  logic [NUM_SRC-1:0][FLIT_SIZE-1:0] src_data_i,
  output logic [NUM_SRC-1:0]                src_credit_o,
  input  logic [NUM_SRC-1:0]                src_eoa_i,
  output logic                              tx_o,
  output logic [FLIT_SIZE-1:0]              data_o,
  input  logic                              credit_i,
  output logic                              eoa_o,
  output logic [$clog2(NUM_SRC)-1:0]        grant_o,
  output logic                              busy_o,
  output logic                              stall_o,
  output logic [31:0]                       flit_cnt_o
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);
  localparam logic [GW-1:0] LAST_SRC  = GW'(NUM_SRC - 1);

  state_e        state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] rr_ptr_q;
  logic [31:0]   flit_cnt_q;
  logic [SW-1:0] stall_cnt_q;
  logic          stall_q;
  logic          busy_q;
  logic          eoa_q;
  logic          eoa_d;
  logic          locked;
  logic [GW-1:0] pick_idx;
  logic          pick_found;

  rr_picker #(
    .N  (NUM_SRC),
    .PW (GW)
  ) u_picker (
    .req_i   (src_tx_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign locked = (state_q == LOCKED);

  // Link side is a pure mux of the granted source: no added latency.
  assign tx_o   = locked & src_tx_i[grant_q];
  assign data_o = locked ? src_data_i[grant_q] : '0;

  always_comb begin
    src_credit_o = '0;
    if (locked) src_credit_o[grant_q] = credit_i;
  end

  assign eoa_d = eoa_q | (&src_eoa_i & ~locked & ~|src_tx_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
      busy_q      <= 1'b0;
      eoa_q       <= 1'b0;
    end else begin
      eoa_q <= eoa_d;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q     <= LOCKED;
            grant_q     <= pick_idx;
            busy_q      <= 1'b1;
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
          end
        end
        LOCKED: begin
          if (!src_tx_i[grant_q]) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
            rr_ptr_q    <= (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;
          end else if (credit_i) begin
            stall_cnt_q <= '0;
            if (flit_cnt_q != '1) flit_cnt_q <= flit_cnt_q + 1'b1;
          end else begin
            // Stall is sticky for the rest of the grant; the counter just saturates.
            if (stall_cnt_q != STALL_MAX) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (stall_cnt_q == STALL_MAX - 1'b1) stall_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign busy_o     = busy_q;
  assign stall_o    = stall_q;
  assign flit_cnt_o = flit_cnt_q;
  assign eoa_o      = eoa_q;

endmodule

// File: tb/tb_inject_arbiter.sv
// tb/tb_inject_arbiter.sv - scoreboard bench for inject_arbiter
module tb_inject_arbiter;

  localparam int NS = 4;
  localparam int FW = 32;
  localparam int SL = 8;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [NS-1:0]          src_tx_i;
  logic [NS-1:0][FW-1:0]  src_data_i;
  logic [NS-1:0]          src_credit_o;
  logic [NS-1:0]          src_eoa_i;
  logic                   tx_o;
  logic [FW-1:0]          data_o;
  logic                   credit_i;
  logic                   eoa_o;
  logic [1:0]             grant_o;
  logic                   busy_o;
  logic                   stall_o;
  logic [31:0]            flit_cnt_o;

  inject_arbiter #(
    .FLIT_SIZE   (FW),
    .NUM_SRC     (NS),
    .STALL_LIMIT (SL)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .src_tx_i     (src_tx_i),
    .src_data_i   (src_data_i),
    .src_credit_o (src_credit_o),
    .src_eoa_i    (src_eoa_i),
    .tx_o         (tx_o),
    .data_o       (data_o),
    .credit_i     (credit_i),
    .eoa_o        (eoa_o),
    .grant_o      (grant_o),
    .busy_o       (busy_o),
    .stall_o      (stall_o),
    .flit_cnt_o   (flit_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    src;
    logic [FW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            errors  = 0;
  int            rem[NS] = '{default: 0};
  int            idx[NS] = '{default: 0};
  logic [NS-1:0] will_xfer = '0;
  logic          check_gap = 1'b0;
  logic          gap_armed = 1'b0;
  logic          prev_busy = 1'b0;
  int            idle_run  = 0;
  logic [NS-1:0] exp_cr;

  function automatic logic [FW-1:0] mk(int s, int k);
    return 32'hC0DE0000 | 32'(s << 8) | 32'(k);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always_comb begin
    for (int s = 0; s < NS; s++) src_data_i[s] = mk(s, idx[s]);
  end

  // Sources advance only after a posedge on which they held credit; inputs change at posedge+1.
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) begin
        if (will_xfer[s]) begin
          idx[s]++;
          rem[s]--;
          if (rem[s] == 0) src_tx_i[s] = 1'b0;
        end
      end
      #1;
    end
  endtask

  task automatic start(int s, int n);
    rem[s]      = n;
    idx[s]      = 0;
    src_tx_i[s] = 1'b1;
  endtask

  task automatic expect_burst(int s, int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.src  = 2'(s);
      e.data = mk(s, k);
      sb.push_back(e);
    end
  endtask

  task automatic wait_all(string name);
    int c = 0;
    int pending;
    pending = 1;
    while (pending != 0 && c < 200) begin
      pending = busy_o ? 1 : 0;
      for (int s = 0; s < NS; s++) if (rem[s] != 0) pending = 1;
      if (pending != 0) begin
        tick(1);
        c++;
      end
    end
    if (c >= 200) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, c);
    end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < NS; s++) will_xfer[s] = !rst_i && src_tx_i[s] && src_credit_o[s];
    if (!check_gap) gap_armed = 1'b0;
    else if (!gap_armed) begin
      idle_run  = 0;
      gap_armed = 1'b1;
    end
    if (!rst_i) begin
      exp_cr = (busy_o && credit_i) ? (NS'(1) << grant_o) : '0;
      chk("credit_isolation", 32'(src_credit_o), 32'(exp_cr));
      if (tx_o) begin
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_flit: got data %0h grant %0d, expected no flit", data_o, grant_o);
        end else begin
          chk("flit_grant", 32'(grant_o), 32'(sb[0].src));
          chk("flit_data", data_o, sb[0].data);
          if (credit_i) void'(sb.pop_front());
        end
      end
      if (busy_o && !prev_busy && check_gap) chk("idle_gap", 32'(idle_run), 32'd1);
      if (!busy_o) idle_run++;
      else idle_run = 0;
      prev_busy = busy_o;
    end
  end

  initial begin
    static int bp[7] = '{1, 0, 0, 1, 1, 0, 1};
    rst_i     = 1'b1;
    credit_i  = 1'b0;
    src_tx_i  = '0;
    src_eoa_i = '0;
    tick(2);
    chk("rst_tx", 32'(tx_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_credit", 32'(src_credit_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_flit_cnt", flit_cnt_o, 32'd0);
    chk("rst_eoa", 32'(eoa_o), 32'd0);
    rst_i = 1'b0;

    // single source, 5 flits
    credit_i = 1'b1;
    start(0, 5);
    expect_burst(0, 5);
    wait_all("single");
    chk("single_flit_cnt", flit_cnt_o, 32'd5);
    chk("single_grant_idle", 32'(grant_o), 32'd0);
    chk("single_tx_idle", 32'(tx_o), 32'd0);

    // rr_ptr is now 1: source 1 beats source 0
    check_gap = 1'b1;
    start(0, 1);
    start(1, 1);
    expect_burst(1, 1);
    expect_burst(0, 1);
    wait_all("rr_ptr1");
    check_gap = 1'b0;
    start(3, 1);
    expect_burst(3, 1);
    wait_all("src3");
    chk("sb_empty_rr", 32'(sb.size()), 32'd0);

    // contention at rr_ptr=0
    check_gap = 1'b1;
    start(0, 3);
    start(2, 3);
    start(3, 3);
    expect_burst(0, 3);
    expect_burst(2, 3);
    expect_burst(3, 3);
    wait_all("contention");
    check_gap = 1'b0;
    chk("sb_empty_contention", 32'(sb.size()), 32'd0);
    chk("contention_flit_cnt", flit_cnt_o, 32'd3);

    // backpressure
    start(1, 4);
    expect_burst(1, 4);
    tick(1);
    for (int i = 0; i < 7; i++) begin
      credit_i = bp[i][0];
      tick(1);
    end
    credit_i = 1'b1;
    wait_all("backpressure");
    chk("bp_flit_cnt", flit_cnt_o, 32'd4);
    chk("bp_no_stall", 32'(stall_o), 32'd0);

    // stall detection
    credit_i = 1'b0;
    start(2, 2);
    expect_burst(2, 2);
    tick(1);
    tick(SL - 1);
    chk("stall_before_limit", 32'(stall_o), 32'd0);
    tick(1);
    chk("stall_at_limit", 32'(stall_o), 32'd1);
    tick(3);
    chk("stall_sticky", 32'(stall_o), 32'd1);
    chk("stall_keeps_grant", 32'(busy_o), 32'd1);
    credit_i = 1'b1;
    tick(2);
    chk("stall_after_xfer", 32'(stall_o), 32'd1);
    chk("stall_src_dropped", 32'(tx_o), 32'd0);
    tick(1);
    chk("stall_cleared", 32'(stall_o), 32'd0);
    chk("stall_idle", 32'(busy_o), 32'd0);
    chk("stall_flit_cnt", flit_cnt_o, 32'd2);
    wait_all("stall");

    // async reset on the 3rd flit of source 3
    start(3, 5);
    expect_burst(3, 2);
    tick(3);
    #2;
    rst_i    = 1'b1;
    src_tx_i = '0;
    rem[3]   = 0;
    #1;
    chk("arst_tx", 32'(tx_o), 32'd0);
    chk("arst_credit", 32'(src_credit_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_flit_cnt", flit_cnt_o, 32'd0);
    chk("sb_empty_arst", 32'(sb.size()), 32'd0);
    tick(2);
    start(1, 2);
    start(3, 1);
    expect_burst(1, 2);
    expect_burst(3, 1);
    rst_i = 1'b0;
    #1;
    chk("arst_release_busy", 32'(busy_o), 32'd0);
    wait_all("after_reset");

    // end of application
    credit_i = 1'b0;
    start(2, 3);
    expect_burst(2, 3);
    tick(1);
    src_eoa_i = '1;
    tick(2);
    chk("eoa_locked", 32'(eoa_o), 32'd0);
    credit_i = 1'b1;
    tick(3);
    chk("eoa_tx_dropped", 32'(eoa_o), 32'd0);
    tick(1);
    chk("eoa_idle_entry", 32'(eoa_o), 32'd0);
    tick(1);
    chk("eoa_set", 32'(eoa_o), 32'd1);
    start(0, 1);
    expect_burst(0, 1);
    tick(1);
    chk("eoa_sticky_busy", 32'(eoa_o), 32'd1);
    wait_all("eoa");
    chk("eoa_sticky_end", 32'(eoa_o), 32'd1);
    chk("sb_empty_final", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
